// File: rtl/mem_access_if.sv
// Bundle of the pipeline-side, data-memory and writeback signals of the mem_access stage.
// The slave modport is the stage itself; master is whatever sits around it.
interface mem_access_if #(
  parameter int XLEN         = 32,
  parameter int MSB_REG_FILE = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         alu_out;
  logic [MSB_REG_FILE-1:0] rd;
  logic                    ctrl_reg_wr;
  logic                    ctrl_mem_wr;
  logic                    ctrl_mem_rd;
  logic                    ctrl_mem_unsigned;
  logic [1:0]              ctrl_mem_size;
  logic [XLEN-1:0]         rs2_data;
  logic                    sel_next_pc;
  logic [XLEN-1:0]         pc_pls4;

  logic                    dmem_req_valid;
  logic                    dmem_req_ready;
  logic [XLEN-1:0]         dmem_addr;
  logic                    dmem_wr;
  logic [XLEN-1:0]         dmem_wdata;
  logic [3:0]              dmem_be;
  logic                    dmem_rsp_valid;
  logic [XLEN-1:0]         dmem_rsp_rdata;

  logic                    wb_valid;
  logic [MSB_REG_FILE-1:0] wb_rd;
  logic [XLEN-1:0]         wb_data;
  logic                    wb_reg_wr;
  logic                    misalign_err;

  modport slave (
    input  in_valid, alu_out, rd, ctrl_reg_wr, ctrl_mem_wr, ctrl_mem_rd,
           ctrl_mem_unsigned, ctrl_mem_size, rs2_data, sel_next_pc, pc_pls4,
           dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata,
    output in_ready, dmem_req_valid, dmem_addr, dmem_wr, dmem_wdata, dmem_be,
           wb_valid, wb_rd, wb_data, wb_reg_wr, misalign_err
  );

  modport master (
    output in_valid, alu_out, rd, ctrl_reg_wr, ctrl_mem_wr, ctrl_mem_rd,
           ctrl_mem_unsigned, ctrl_mem_size, rs2_data, sel_next_pc, pc_pls4,
           dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata,
    input  in_ready, dmem_req_valid, dmem_addr, dmem_wr, dmem_wdata, dmem_be,
           wb_valid, wb_rd, wb_data, wb_reg_wr, misalign_err
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results straight to writeback, or issues
// aligned byte/half/word loads and stores to data memory and extends load data.
module mem_access #(
  parameter int XLEN         = 32,
  parameter int MSB_REG_FILE = 5
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                  state;
  state_t                  state_next;

  logic                    accept;
  logic                    is_mem;
  logic                    misaligned;
  logic [3:0]              be_calc;
  logic [XLEN-1:0]         wdata_calc;

  logic [MSB_REG_FILE-1:0] rd_q;
  logic                    reg_wr_q;
  logic                    unsigned_q;
  logic [1:0]              size_q;
  logic [1:0]              addr_lo_q;
  logic [15:0]             lane;
  logic [XLEN-1:0]         load_ext;

  assign is_mem = bus.ctrl_mem_wr | bus.ctrl_mem_rd;
  assign accept = bus.in_valid && (state == IDLE);

  // Byte enables, replicated store data and alignment are all decided from the incoming op.
  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = bus.rs2_data;
    case (bus.ctrl_mem_size)
      2'b00: begin
        be_calc    = 4'b0001 << bus.alu_out[1:0];
        wdata_calc = {(XLEN/8){bus.rs2_data[7:0]}};
      end
      2'b01: begin
        misaligned = bus.alu_out[0];
        be_calc    = bus.alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {(XLEN/16){bus.rs2_data[15:0]}};
      end
      default: misaligned = |bus.alu_out[1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next         = state;
    bus.in_ready       = 1'b0;
    bus.dmem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && is_mem && !misaligned) state_next = REQ;
      end
      REQ: begin
        bus.dmem_req_valid = 1'b1;
        if (bus.dmem_req_ready) state_next = bus.dmem_wr ? IDLE : WAIT;
      end
      WAIT: begin
        if (bus.dmem_rsp_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pick the addressed lane out of the response word, then sign- or zero-extend it.
  assign lane = 16'(bus.dmem_rsp_rdata >> {addr_lo_q, 3'b000});

  always_comb begin
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {{(XLEN-8){1'b0}}, lane[7:0]}
                                     : {{(XLEN-8){lane[7]}}, lane[7:0]};
      2'b01:   load_ext = unsigned_q ? {{(XLEN-16){1'b0}}, lane}
                                     : {{(XLEN-16){lane[15]}}, lane};
      default: load_ext = bus.dmem_rsp_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q             <= '0;
      reg_wr_q         <= 1'b0;
      unsigned_q       <= 1'b0;
      size_q           <= 2'b00;
      addr_lo_q        <= 2'b00;
      bus.dmem_addr    <= '0;
      bus.dmem_wr      <= 1'b0;
      bus.dmem_wdata   <= '0;
      bus.dmem_be      <= 4'b0000;
      bus.wb_valid     <= 1'b0;
      bus.wb_rd        <= '0;
      bus.wb_data      <= '0;
      bus.wb_reg_wr    <= 1'b0;
      bus.misalign_err <= 1'b0;
    end else begin
      bus.wb_valid     <= 1'b0;
      bus.misalign_err <= 1'b0;

      if (accept) begin
        rd_q           <= bus.rd;
        reg_wr_q       <= bus.ctrl_reg_wr;
        unsigned_q     <= bus.ctrl_mem_unsigned;
        size_q         <= bus.ctrl_mem_size;
        addr_lo_q      <= bus.alu_out[1:0];
        bus.dmem_addr  <= {bus.alu_out[XLEN-1:2], 2'b00};
        bus.dmem_wr    <= bus.ctrl_mem_wr;
        bus.dmem_wdata <= wdata_calc;
        bus.dmem_be    <= be_calc;

        if (!is_mem) begin
          bus.wb_valid  <= 1'b1;
          bus.wb_rd     <= bus.rd;
          bus.wb_reg_wr <= bus.ctrl_reg_wr;
          bus.wb_data   <= bus.sel_next_pc ? bus.pc_pls4 : bus.alu_out;
        end else if (misaligned) begin
          bus.wb_valid     <= 1'b1;
          bus.wb_rd        <= bus.rd;
          bus.wb_reg_wr    <= 1'b0;
          bus.wb_data      <= bus.alu_out;
          bus.misalign_err <= 1'b1;
        end
      end

      // A store retires as soon as memory takes it; a load retires on its response.
      if ((state == REQ) && bus.dmem_req_ready && bus.dmem_wr) begin
        bus.wb_valid  <= 1'b1;
        bus.wb_rd     <= rd_q;
        bus.wb_reg_wr <= 1'b0;
      end

      if ((state == WAIT) && bus.dmem_rsp_valid) begin
        bus.wb_valid  <= 1'b1;
        bus.wb_rd     <= rd_q;
        bus.wb_reg_wr <= reg_wr_q;
        bus.wb_data   <= load_ext;
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized ops compared
// against a byte-lane arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_access;
  logic clk = 1'b0;
  logic rst;
  int   n_checks;
  int   n_pass;

  always #5 clk = ~clk;

  mem_access_if #(.XLEN(32), .MSB_REG_FILE(5)) bus ();
  mem_access #(.XLEN(32), .MSB_REG_FILE(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        reg_wr, mem_wr, mem_rd, uns, sel;
    logic [1:0]  size;
    logic [31:0] rs2, pc;
  } op_t;

  typedef struct {
    logic        req, mis, wr, reg_wr;
    logic [31:0] addr, wdata, data;
    logic [3:0]  be;
  } exp_t;

  typedef struct {
    int          req_cycles, mis_count, latency;
    logic        unstable, ready_busy, wb_seen, timeout, ready_at_wb;
    logic [31:0] addr, wdata, wb_data;
    logic [3:0]  be;
    logic        wr, wb_reg_wr, after_wb, after_mis;
    logic [4:0]  wb_rd;
  } obs_t;

  // Reference model: what the op must do, from byte-lane arithmetic on the address.
  function automatic exp_t model(op_t op, logic [31:0] rdata);
    exp_t   e;
    int     a, nb;
    logic   is_mem;
    longint md, lv;
    is_mem  = op.mem_wr || op.mem_rd;
    a       = int'(op.alu % 4);
    nb      = (op.size == 2'd0) ? 1 : (op.size == 2'd1) ? 2 : 4;
    e.wr    = op.mem_wr;
    e.mis   = is_mem && (op.alu % nb != 0);
    e.req   = is_mem && !e.mis;
    e.addr  = op.alu - op.alu % 4;
    e.be    = 4'(((2 ** nb) - 1) << a);
    e.wdata = (nb == 1) ? 32'(op.rs2 % 256) * 32'h0101_0101 :
              (nb == 2) ? 32'(op.rs2 % 65536) * 32'h0001_0001 : op.rs2;
    if (!is_mem) begin
      e.data   = op.sel ? op.pc : op.alu;
      e.reg_wr = op.reg_wr;
    end else begin
      md = longint'(1) << (8 * nb);
      lv = (longint'(rdata) >> (8 * a)) % md;
      if (!op.uns && nb < 4 && lv >= md / 2) lv = lv - md;
      e.data   = 32'(lv);
      e.reg_wr = (e.mis || op.mem_wr) ? 1'b0 : op.reg_wr;
    end
    return e;
  endfunction

  function automatic op_t rand_op(int kind);
    op_t op;
    int  k;
    op.alu    = $urandom;
    op.rd     = 5'($urandom);
    op.reg_wr = 1'($urandom);
    op.uns    = 1'($urandom);
    op.sel    = 1'($urandom);
    op.size   = 2'($urandom);
    op.rs2    = $urandom;
    op.pc     = $urandom;
    k = (kind == 3) ? $urandom_range(0, 3) : kind;
    op.mem_rd = (k == 1) || (k == 3);
    op.mem_wr = (k == 2) || (k == 3);
    if ($urandom_range(0, 3) != 0) begin
      if (op.size == 2'd1) op.alu[0] = 1'b0;
      else if (op.size[1]) op.alu[1:0] = 2'b00;
    end
    return op;
  endfunction

  task automatic drive_op(input op_t op);
    bus.alu_out           = op.alu;
    bus.rd                = op.rd;
    bus.ctrl_reg_wr       = op.reg_wr;
    bus.ctrl_mem_wr       = op.mem_wr;
    bus.ctrl_mem_rd       = op.mem_rd;
    bus.ctrl_mem_unsigned = op.uns;
    bus.ctrl_mem_size     = op.size;
    bus.rs2_data          = op.rs2;
    bus.sel_next_pc       = op.sel;
    bus.pc_pls4           = op.pc;
  endtask

  // Issues one op from IDLE, plays memory with the given delays and records what the DUT did.
  task automatic run_op(input op_t op, input int ready_dly, input int rsp_dly,
                        input logic [31:0] rdata, output obs_t o);
    int   cycles, wait_cnt;
    logic accepted;
    o.req_cycles = 0; o.mis_count = 0; o.latency = -1;
    o.unstable = 0; o.ready_busy = 0; o.wb_seen = 0; o.timeout = 0; o.ready_at_wb = 0;
    o.addr = '0; o.wdata = '0; o.wb_data = '0; o.be = '0; o.wr = 0; o.wb_reg_wr = 0;
    o.after_wb = 0; o.after_mis = 0; o.wb_rd = '0;
    drive_op(op);
    bus.in_valid       = 1'b1;
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rsp_valid = 1'($urandom);
    bus.dmem_rsp_rdata = $urandom;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cycles = 0; wait_cnt = 0; accepted = 0;
    while (1) begin
      if (bus.misalign_err) o.mis_count++;
      if (bus.dmem_req_valid) begin
        if (o.req_cycles == 0) begin
          o.addr = bus.dmem_addr; o.be = bus.dmem_be; o.wdata = bus.dmem_wdata; o.wr = bus.dmem_wr;
        end else if (o.addr !== bus.dmem_addr || o.be !== bus.dmem_be ||
                     o.wdata !== bus.dmem_wdata || o.wr !== bus.dmem_wr) begin
          o.unstable = 1;
        end
        if (bus.in_ready) o.ready_busy = 1;
        o.req_cycles++;
      end
      if (bus.wb_valid) begin
        o.wb_seen = 1; o.wb_data = bus.wb_data; o.wb_rd = bus.wb_rd;
        o.wb_reg_wr = bus.wb_reg_wr; o.latency = cycles; o.ready_at_wb = bus.in_ready;
        break;
      end
      if (cycles >= 60) begin
        o.timeout = 1;
        break;
      end
      if (bus.dmem_req_valid) begin
        bus.dmem_req_ready = (o.req_cycles > ready_dly);
        bus.dmem_rsp_valid = 1'($urandom);
        bus.dmem_rsp_rdata = $urandom;
        accepted = bus.dmem_req_ready;
      end else begin
        bus.dmem_req_ready = 1'b0;
        if (accepted) begin
          if (bus.in_ready) o.ready_busy = 1;
          bus.dmem_rsp_valid = (wait_cnt >= rsp_dly);
          bus.dmem_rsp_rdata = (wait_cnt >= rsp_dly) ? rdata : $urandom;
          wait_cnt++;
        end else begin
          bus.dmem_rsp_valid = 1'b0;
        end
      end
      @(negedge clk);
      cycles++;
    end
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
    @(negedge clk);
    o.after_wb  = bus.wb_valid;
    o.after_mis = bus.misalign_err;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0;
    bus.dmem_rsp_rdata = '0;
    drive_op(rand_op(0));
    repeat (2) @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.wb_valid !== 1'b0) $display("[TB] FAIL reset_wb_valid: got %b want 0", bus.wb_valid); else n_pass++;
    n_checks++; if (bus.wb_reg_wr !== 1'b0) $display("[TB] FAIL reset_wb_reg_wr: got %b want 0", bus.wb_reg_wr); else n_pass++;
    n_checks++; if (bus.wb_rd !== 5'd0) $display("[TB] FAIL reset_wb_rd: got %0d want 0", bus.wb_rd); else n_pass++;
    n_checks++; if (bus.wb_data !== 32'h0) $display("[TB] FAIL reset_wb_data: got %h want 0", bus.wb_data); else n_pass++;
    n_checks++; if (bus.misalign_err !== 1'b0) $display("[TB] FAIL reset_misalign: got %b want 0", bus.misalign_err); else n_pass++;
    n_checks++; if (bus.dmem_req_valid !== 1'b0) $display("[TB] FAIL reset_req_valid: got %b want 0", bus.dmem_req_valid); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nonmem;
    op_t  op;
    obs_t o;
    op = rand_op(0);
    op.alu = 32'h10; op.rd = 5'd3; op.reg_wr = 1'b1; op.sel = 1'b0;
    run_op(op, 0, 0, 32'h0, o);
    n_checks++; if (o.latency !== 0) $display("[TB] FAIL alu_latency: got %0d want 0", o.latency); else n_pass++;
    n_checks++; if (o.wb_rd !== 5'd3) $display("[TB] FAIL alu_wb_rd: got %0d want 3", o.wb_rd); else n_pass++;
    n_checks++; if (o.wb_data !== 32'h10) $display("[TB] FAIL alu_wb_data: got %h want 00000010", o.wb_data); else n_pass++;
    n_checks++; if (o.wb_reg_wr !== 1'b1) $display("[TB] FAIL alu_wb_reg_wr: got %b want 1", o.wb_reg_wr); else n_pass++;
    n_checks++; if (o.ready_at_wb !== 1'b1) $display("[TB] FAIL alu_in_ready: got %b want 1", o.ready_at_wb); else n_pass++;
    n_checks++; if (o.req_cycles !== 0) $display("[TB] FAIL alu_no_req: got %0d want 0", o.req_cycles); else n_pass++;
    op.sel = 1'b1; op.pc = 32'h44;
    run_op(op, 0, 0, 32'h0, o);
    n_checks++; if (o.wb_data !== 32'h44) $display("[TB] FAIL jump_wb_data: got %h want 00000044", o.wb_data); else n_pass++;
    n_checks++; if (o.after_wb !== 1'b0) $display("[TB] FAIL jump_wb_pulse: got %b want 0", o.after_wb); else n_pass++;
  endtask

  task automatic test_store_byte;
    op_t  op;
    obs_t o;
    op = rand_op(2);
    op.alu = 32'h103; op.size = 2'b00; op.rs2 = 32'hAB; op.mem_rd = 1'b0; op.reg_wr = 1'b1;
    run_op(op, 2, 0, 32'h0, o);
    n_checks++; if (o.req_cycles !== 3) $display("[TB] FAIL sb_req_cycles: got %0d want 3", o.req_cycles); else n_pass++;
    n_checks++; if (o.unstable !== 1'b0) $display("[TB] FAIL sb_req_stable: got %b want 0", o.unstable); else n_pass++;
    n_checks++; if (o.addr !== 32'h100) $display("[TB] FAIL sb_addr: got %h want 00000100", o.addr); else n_pass++;
    n_checks++; if (o.be !== 4'b1000) $display("[TB] FAIL sb_be: got %b want 1000", o.be); else n_pass++;
    n_checks++; if (o.wdata !== 32'hABABABAB) $display("[TB] FAIL sb_wdata: got %h want abababab", o.wdata); else n_pass++;
    n_checks++; if (o.wr !== 1'b1) $display("[TB] FAIL sb_wr: got %b want 1", o.wr); else n_pass++;
    n_checks++; if (o.wb_seen !== 1'b1 || o.latency !== 3) $display("[TB] FAIL sb_wb_timing: got seen=%b lat=%0d want seen=1 lat=3", o.wb_seen, o.latency); else n_pass++;
    n_checks++; if (o.wb_reg_wr !== 1'b0) $display("[TB] FAIL sb_wb_reg_wr: got %b want 0", o.wb_reg_wr); else n_pass++;
  endtask

  task automatic test_load_half;
    op_t  op;
    obs_t o;
    op = rand_op(1);
    op.alu = 32'h202; op.size = 2'b01; op.uns = 1'b0; op.reg_wr = 1'b1; op.rd = 5'd7;
    run_op(op, 0, 1, 32'h8001_1234, o);
    n_checks++; if (o.wb_data !== 32'hFFFF8001) $display("[TB] FAIL lh_signed: got %h want ffff8001", o.wb_data); else n_pass++;
    n_checks++; if (o.be !== 4'b1100 || o.addr !== 32'h200) $display("[TB] FAIL lh_req: got be=%b addr=%h want be=1100 addr=00000200", o.be, o.addr); else n_pass++;
    n_checks++; if (o.wb_reg_wr !== 1'b1 || o.wb_rd !== 5'd7) $display("[TB] FAIL lh_wb_dest: got wr=%b rd=%0d want wr=1 rd=7", o.wb_reg_wr, o.wb_rd); else n_pass++;
    op.uns = 1'b1;
    run_op(op, 1, 0, 32'h8001_1234, o);
    n_checks++; if (o.wb_data !== 32'h00008001) $display("[TB] FAIL lhu_unsigned: got %h want 00008001", o.wb_data); else n_pass++;
  endtask

  task automatic test_misalign;
    op_t  op;
    obs_t o;
    op = rand_op(1);
    op.alu = 32'h301; op.size = 2'b10; op.reg_wr = 1'b1;
    run_op(op, 0, 0, 32'h0, o);
    n_checks++; if (o.mis_count !== 1 || o.after_mis !== 1'b0) $display("[TB] FAIL lw_mis_pulse: got count=%0d after=%b want 1/0", o.mis_count, o.after_mis); else n_pass++;
    n_checks++; if (o.req_cycles !== 0) $display("[TB] FAIL lw_mis_no_req: got %0d want 0", o.req_cycles); else n_pass++;
    n_checks++; if (o.wb_seen !== 1'b1 || o.latency !== 0) $display("[TB] FAIL lw_mis_wb: got seen=%b lat=%0d want 1/0", o.wb_seen, o.latency); else n_pass++;
    n_checks++; if (o.wb_reg_wr !== 1'b0) $display("[TB] FAIL lw_mis_reg_wr: got %b want 0", o.wb_reg_wr); else n_pass++;
    op = rand_op(2);
    op.alu = 32'h101; op.size = 2'b01;
    run_op(op, 0, 0, 32'h0, o);
    n_checks++; if (o.mis_count !== 1 || o.req_cycles !== 0) $display("[TB] FAIL sh_mis: got count=%0d req=%0d want 1/0", o.mis_count, o.req_cycles); else n_pass++;
  endtask

  task automatic test_reset_in_wait;
    op_t op;
    int  wb_hits;
    op = rand_op(1);
    op.alu = 32'h400; op.size = 2'b10; op.reg_wr = 1'b1;
    drive_op(op);
    bus.in_valid = 1'b1; bus.dmem_req_ready = 1'b1; bus.dmem_rsp_valid = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.dmem_req_ready = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.dmem_req_valid !== 1'b0) $display("[TB] FAIL rstwait_in_wait: got ready=%b req=%b want 0/0", bus.in_ready, bus.dmem_req_valid); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL rstwait_async_ready: got %b want 1", bus.in_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    bus.dmem_rsp_valid = 1'b1; bus.dmem_rsp_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.dmem_rsp_valid = 1'b0;
    wb_hits = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.wb_valid) wb_hits++;
      @(negedge clk);
    end
    n_checks++; if (wb_hits !== 0) $display("[TB] FAIL rstwait_no_wb: got %0d want 0", wb_hits); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL rstwait_idle: got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_back_to_back;
    op_t  op, prev;
    exp_t e;
    for (int i = 0; i <= 20; i++) begin
      n_checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL b2b_ready[%0d]: got %b want 1", i, bus.in_ready); else n_pass++;
      if (i > 0) begin
        e = model(prev, 32'h0);
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_data !== e.data || bus.wb_rd !== prev.rd || bus.wb_reg_wr !== e.reg_wr)
          $display("[TB] FAIL b2b_wb[%0d]: got v=%b d=%h rd=%0d w=%b want v=1 d=%h rd=%0d w=%b",
                   i, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_reg_wr, e.data, prev.rd, e.reg_wr);
        else n_pass++;
      end
      op = rand_op(0);
      drive_op(op);
      bus.in_valid = (i < 20);
      prev = op;
      @(negedge clk);
    end
    n_checks++; if (bus.wb_valid !== 1'b0) $display("[TB] FAIL b2b_idle_wb: got %b want 0", bus.wb_valid); else n_pass++;
  endtask

  task automatic test_random;
    op_t         op;
    obs_t        o;
    exp_t        e;
    int          rdy, rsp, want_lat;
    logic [31:0] rdata;
    for (int i = 0; i < 60; i++) begin
      op    = rand_op(3);
      rdy   = $urandom_range(0, 3);
      rsp   = $urandom_range(0, 3);
      rdata = $urandom;
      e     = model(op, rdata);
      run_op(op, rdy, rsp, rdata, o);
      want_lat = !e.req ? 0 : e.wr ? rdy + 1 : rdy + rsp + 2;
      n_checks++; if (o.timeout !== 1'b0 || o.latency !== want_lat) $display("[TB] FAIL rnd_latency[%0d]: got %0d want %0d", i, o.latency, want_lat); else n_pass++;
      n_checks++; if (o.mis_count !== int'(e.mis)) $display("[TB] FAIL rnd_mis[%0d]: got %0d want %0d", i, o.mis_count, e.mis); else n_pass++;
      n_checks++; if (o.wb_reg_wr !== e.reg_wr || o.wb_rd !== op.rd) $display("[TB] FAIL rnd_wb_dest[%0d]: got w=%b rd=%0d want w=%b rd=%0d", i, o.wb_reg_wr, o.wb_rd, e.reg_wr, op.rd); else n_pass++;
      n_checks++; if (o.req_cycles !== (e.req ? rdy + 1 : 0) || o.unstable !== 1'b0) $display("[TB] FAIL rnd_req_len[%0d]: got %0d unstable=%b want %0d", i, o.req_cycles, o.unstable, e.req ? rdy + 1 : 0); else n_pass++;
      if (e.req) begin
        n_checks++; if (o.addr !== e.addr || o.be !== e.be || o.wr !== e.wr) $display("[TB] FAIL rnd_req[%0d]: got a=%h be=%b wr=%b want a=%h be=%b wr=%b", i, o.addr, o.be, o.wr, e.addr, e.be, e.wr); else n_pass++;
        n_checks++; if (o.ready_busy !== 1'b0) $display("[TB] FAIL rnd_stall[%0d]: got in_ready high while busy", i); else n_pass++;
      end
      if (e.req && e.wr) begin
        n_checks++; if (o.wdata !== e.wdata) $display("[TB] FAIL rnd_wdata[%0d]: got %h want %h", i, o.wdata, e.wdata); else n_pass++;
      end
      if (!(op.mem_wr || op.mem_rd) || (e.req && !e.wr)) begin
        n_checks++; if (o.wb_data !== e.data) $display("[TB] FAIL rnd_wb_data[%0d]: got %h want %h", i, o.wb_data, e.data); else n_pass++;
      end
      n_checks++; if (o.after_wb !== 1'b0 || o.after_mis !== 1'b0) $display("[TB] FAIL rnd_pulse[%0d]: got wb=%b mis=%b want 0/0", i, o.after_wb, o.after_mis); else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset;
    test_nonmem;
    test_store_byte;
    test_load_half;
    test_misalign;
    test_reset_in_wait;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 Parameter MSB_REG_FILE, default 5, destination-register index width.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  execute-stage result valid this cycle.
REQ-006 in_ready  out  1  stage can accept; in_ready low is the pipeline stall.
REQ-007 alu_out  in  XLEN  ALU result, or effective address for memory ops.
REQ-008 rd  in  MSB_REG_FILE  destination register index.
REQ-009 ctrl_reg_wr, ctrl_mem_wr, ctrl_mem_rd, ctrl_mem_unsigned  in  1 each  op controls.
REQ-010 ctrl_mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-011 rs2_data  in  XLEN  store data.
REQ-012 sel_next_pc  in  1  jump op; write back pc_pls4 instead of alu_out.
REQ-013 pc_pls4  in  XLEN  link address.
REQ-014 dmem_req_valid  out  1  memory request valid.
REQ-015 dmem_req_ready  in  1  memory accepts request.
REQ-016 dmem_addr  out  XLEN  word address, alu_out with bits [1:0] forced to 0.
REQ-017 dmem_wr  out  1  1 store, 0 load.
REQ-018 dmem_wdata  out  XLEN  lane-replicated store data.
REQ-019 dmem_be  out  4  byte enables.
REQ-020 dmem_rsp_valid  in  1, dmem_rsp_rdata  in  XLEN  load response.
REQ-021 wb_valid  out  1, wb_rd  out  MSB_REG_FILE, wb_data  out  XLEN, wb_reg_wr  out  1  registered writeback.
REQ-022 misalign_err  out  1  one-cycle error pulse.

Function
REQ-023 FSM states IDLE, REQ, WAIT; in_ready = (state == IDLE).
REQ-024 Accept when in_valid and in_ready; all input fields latched on accept.
REQ-025 Non-memory op accepted at cycle T: at T+1 wb_valid=1, wb_rd=rd, wb_reg_wr=ctrl_reg_wr, wb_data = pc_pls4 if sel_next_pc else alu_out; state stays IDLE (back-to-back throughput of 1 per cycle).
REQ-026 Memory op (ctrl_mem_wr or ctrl_mem_rd) accepted and aligned: go to REQ; if both set, treated as store.
REQ-027 Alignment: half requires alu_out[0]=0; word requires alu_out[1:0]=00.
REQ-028 Misaligned memory op: no memory request; at T+1 misalign_err=1 and wb_valid=1 with wb_reg_wr=0; state stays IDLE.
REQ-029 REQ: dmem_req_valid=1, with dmem_addr, dmem_wr, dmem_wdata and dmem_be held stable until dmem_req_ready; dmem_req_valid is 0 in IDLE and WAIT.
REQ-030 Store accepted by memory: next cycle wb_valid=1, wb_reg_wr=0; state goes to IDLE.
REQ-031 Load accepted by memory: state goes to WAIT.
REQ-032 dmem_rsp_valid is honoured only in WAIT and ignored in IDLE and REQ.
REQ-033 WAIT with dmem_rsp_valid: next cycle wb_valid=1, wb_reg_wr=ctrl_reg_wr, wb_data=extended load data; state goes to IDLE.
REQ-034 Byte enables: byte, dmem_be = 0001 << addr[1:0]; half, 0011 if addr[1]=0 else 1100; word, 1111.
REQ-035 Write data: byte, rs2_data[7:0] replicated x4; half, rs2_data[15:0] replicated x2; word, rs2_data.
REQ-036 Load extract: lane = dmem_rsp_rdata >> (8*addr[1:0]).
REQ-037 Load extension: byte and half are sign-extended unless ctrl_mem_unsigned=1, in which case they are zero-extended; word is passed unchanged.
REQ-038 wb_valid and misalign_err are single-cycle pulses, 0 in every cycle not listed above.

Reset
REQ-039 rst=1 forces, asynchronously: state IDLE, wb_valid 0, wb_reg_wr 0, wb_rd 0, wb_data 0, misalign_err 0, dmem_req_valid 0, in_ready 1.
REQ-040 Reset during REQ or WAIT abandons the transaction with no writeback; a late dmem_rsp_valid after reset is ignored.

Verification
REQ-041 Non-memory op, alu_out=0x00000010, rd=3, reg_wr=1 -> next cycle wb_valid=1, wb_rd=3, wb_data=0x00000010; in_ready stays 1.
REQ-042 Store byte, addr=0x103, rs2=0x000000AB, dmem_req_ready delayed 2 cycles -> dmem_addr=0x100, be=1000, wdata=0xABABABAB held 3 cycles; then wb_valid=1, wb_reg_wr=0.
REQ-043 Load half signed, addr=0x202, rdata=0x8001_1234 -> wb_data=0xFFFF8001; the same load unsigned -> wb_data=0x00008001.
REQ-044 Load word, addr=0x301 -> misalign_err=1 one cycle, no dmem_req_valid, wb_reg_wr=0.
REQ-045 rst asserted in WAIT, then rsp_valid one cycle later -> no wb_valid; in_ready=1 immediately.
REQ-046 Jump, sel_next_pc=1, pc_pls4=0x44 -> wb_data=0x00000044.
